// File: rtl/button_pulse.sv
// Push-button conditioner: 2-FF synchroniser, stable-time debounce FSM, one-cycle press pulse.
// Optional auto-repeat while held is enabled by defining BUTTON_PULSE_AUTO_REPEAT_EN.
module button_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 24,
  parameter bit          BTN_ACTIVE_LOW  = 1'b0
`ifdef BUTTON_PULSE_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
`endif
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic btn_in,
  output logic pulse,
  output logic level
);

  localparam logic [1:0] ST_IDLE          = 2'd0;
  localparam logic [1:0] ST_CHECK_PRESS   = 2'd1;
  localparam logic [1:0] ST_HELD          = 2'd2;
  localparam logic [1:0] ST_CHECK_RELEASE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             pressed_raw;
  logic             s1_q, s2_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;
  logic             press_pulse;

  // Normalise polarity before synchronising so everything downstream means "pressed".
  assign pressed_raw = btn_in ^ BTN_ACTIVE_LOW;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pressed_raw;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s2_q) begin
          state_d = ST_CHECK_PRESS;
          cnt_d   = '0;
        end
      end
      ST_CHECK_PRESS: begin
        if (!s2_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_HELD;
          cnt_d       = '0;
          press_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!s2_q) begin
          state_d = ST_CHECK_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_CHECK_RELEASE: begin
        if (s2_q) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == ST_HELD) || (state_d == ST_CHECK_RELEASE);
  end

`ifdef BUTTON_PULSE_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] RPT_ONE         = RPT_W'(1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_armed_q, rpt_armed_d;
  logic             rpt_pulse;

  // Counts only while resting in HELD; CHECK_RELEASE freezes it so a release bounce resumes.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_armed_d = rpt_armed_q;
    rpt_pulse   = 1'b0;
    if (state_q == ST_HELD && s2_q) begin
      if (rpt_cnt_q == (rpt_armed_q ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
        rpt_pulse   = 1'b1;
        rpt_cnt_d   = '0;
        rpt_armed_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_ONE;
      end
    end else if ((state_q == ST_CHECK_PRESS && state_d == ST_HELD) ||
                 (state_q == ST_CHECK_RELEASE && state_d == ST_IDLE)) begin
      rpt_cnt_d   = '0;
      rpt_armed_d = 1'b0;
    end
    pulse_d = press_pulse | rpt_pulse;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end
`else
  assign pulse_d = press_pulse;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;

endmodule

// File: doc/button_pulse.md
Name: button_pulse

Overview:
- Conditions one raw push-button input into a clean single-cycle enable pulse for the dice selector's inc/dec inputs.
- Synchronises the asynchronous pad signal, debounces it with a stable-time counter FSM, and emits exactly one Clk-wide pulse per accepted press.
- One instance per button; instantiated directly upstream of the dice selection stage.

Parameters:
- DEBOUNCE_CYCLES, 500000, Clk cycles the synchronised input must stay stable before a press or release is accepted (10 ms at 50 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 24, width of the internal counters.
- BTN_ACTIVE_LOW, 0, 1 = pressed button drives btn_in low; 0 = pressed drives high.
- REPEAT_DELAY, 25000000, cycles held in HELD before the first auto-repeat pulse (auto-repeat build only).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (auto-repeat build only).

Ports:
- Clk  input  1  system clock, all logic on rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- btn_in  input  1  raw asynchronous button pad signal.
- pulse  output  1  registered one-cycle enable per accepted press.
- level  output  1  registered debounced pressed state.

Behaviour:
- Reset: Reset_n is asynchronous, active-low; clock is Clk.
  - Assertion forces: sync regs = released value, state = IDLE, counters = 0, pulse = 0, level = 0.
  - Reset mid-count or mid-hold discards all progress; no pulse is issued on or after release of reset until a full new press is accepted.
- Input path:
  - btn_in is XORed with BTN_ACTIVE_LOW to give a "pressed" bit.
  - That bit passes through a 2-FF synchroniser (s1, s2). Only s2 is used downstream.
- FSM states and transitions:
  - IDLE (released, stable): s2=1 -> CHECK_PRESS, cnt=0.
  - CHECK_PRESS:
    - s2=0 (bounce) -> IDLE, cnt=0, no pulse.
    - s2=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, pulse=1 for one cycle.
    - Otherwise cnt+1.
  - HELD (pressed, stable): s2=0 -> CHECK_RELEASE, cnt=0.
  - CHECK_RELEASE:
    - s2=1 (bounce) -> HELD, no new pulse.
    - s2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE.
    - Otherwise cnt+1.
- level = 1 in HELD and CHECK_RELEASE, 0 otherwise, registered with the state.
- pulse:
  - Registered, high exactly one cycle per accepted press. Never high two consecutive cycles.
  - Never high in IDLE, CHECK_PRESS or CHECK_RELEASE.
- Latency: counting the first Clk edge that samples btn_in pressed as edge 1, pulse is high in the cycle after edge DEBOUNCE_CYCLES+3 (input held stable throughout).
- Release debounce has the same length.
- Any bounce shorter than DEBOUNCE_CYCLES, in either direction, produces no extra pulse.
- Counter never wraps: it is cleared on every state change and saturates logically at DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: BUTTON_PULSE_AUTO_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter runs.
  - After REPEAT_DELAY cycles in HELD, pulse is asserted for one cycle. Further single-cycle pulses follow every REPEAT_PERIOD cycles while still in HELD.
  - The repeat counter clears on entry to HELD and whenever HELD is left. It freezes in CHECK_RELEASE and resumes if a bounce returns the FSM to HELD.
  - Reset clears it.
- Not defined: exactly one pulse per press. The repeat counter and both REPEAT_* parameters are absent from the netlist.

Test Plan:
- Reset behaviour: hold Reset_n=0 with btn_in=1 for 10 cycles, then release -> pulse=0 and level=0 during reset. With DEBOUNCE_CYCLES=4, one pulse appears at edge 7 after reset release; level rises with it.
- Clean press: DEBOUNCE_CYCLES=4, btn_in 0->1 held 20 cycles -> pulse high in exactly one cycle (after edge 7), level=1 from the same cycle. Release -> level falls 7 edges after btn_in returns to 0, with no pulse.
- Bounce rejection: DEBOUNCE_CYCLES=4, btn_in toggles 1,0,1,1,0,1 one cycle each, then stays 1 -> no pulse during the toggling; single pulse 7 edges after the final rise.
- Release bounce: while HELD, btn_in glitches 0 for 2 cycles then back to 1 -> level stays 1, pulse stays 0.
- Active-low and reset mid-count: BTN_ACTIVE_LOW=1 and a press drives btn_in to 0 -> one pulse. Asserting Reset_n for one cycle at cnt=2 -> no pulse; a full new 7-edge window is required.
- Auto-repeat (macro defined): DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, hold 40 cycles -> pulses at press acceptance, +10, +15, +20, +25, +30, +35 cycles. Without the macro -> exactly one pulse.
